// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions used by both the write-side and the
// read-side pointer controllers.
//   DEFAULT_ADDRSIZE : default RAM address width (depth = 2**DEFAULT_ADDRSIZE)
//   ptr_t            : pointer type, DEFAULT_ADDRSIZE+1 bits (extra wrap bit)
//   bin2gray/gray2bin: pointer code conversions on ptr_t
package fifo_pkg;

  localparam int unsigned DEFAULT_ADDRSIZE = 4;

  typedef logic [DEFAULT_ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = '0;
    for (int unsigned i = 0; i <= DEFAULT_ADDRSIZE; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser bringing the read-domain Gray pointer into the write
// clock domain.
//   wclk     : write-domain clock
//   wrst     : synchronous active-high reset
//   rptr     : Gray read pointer, asynchronous to wclk
//   wq2_rptr : synchronised Gray read pointer (two wclk stages of latency)
module sync_r2w #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] rptr,
  output logic [WIDTH-1:0] wq2_rptr
);

  logic [WIDTH-1:0] wq1_rptr;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller of the asynchronous FIFO.
//   wclk         : write-domain clock
//   wrst         : synchronous active-high reset
//   winc         : producer write request
//   rptr         : Gray read pointer from the read domain (asynchronous)
//   wen          : RAM write enable (winc & ~wfull)
//   waddr        : RAM write address (low bits of the binary write counter)
//   wptr         : registered Gray write pointer sent to the read domain
//   wfull        : registered full flag
//   walmost_full : registered flag, fill level >= AFULL_LEVEL
//   wlevel       : registered fill level 0..2**ADDRSIZE (never under-reports)
//   woverflow    : sticky flag, a write was attempted while full
//   wovf_clr     : clears woverflow (a simultaneous overflow wins)
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE    = DEFAULT_ADDRSIZE,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  input  logic                wovf_clr
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              wfull_val;
  logic              walmost_full_val;

  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .wclk     (wclk),
    .wrst     (wrst),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  // wen is held low while reset is applied so no RAM write is issued before
  // the pointers are valid; outside reset it is exactly winc & ~wfull.
  assign wen   = winc & ~wfull & ~wrst;
  assign waddr = wbin[ADDRSIZE-1:0];

  always_comb begin
    wbinnext  = wbin + PW'(wen);
    wgraynext = (wbinnext >> 1) ^ wbinnext;
    rbin_s    = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
    level_next       = wbinnext - rbin_s;
    walmost_full_val = (level_next >= PW'(AFULL_LEVEL));
    // Full when the pointers match except for the two MSBs (Gray wrap bits).
    wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                               wq2_rptr[ADDRSIZE-2:0]});
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_val;
      walmost_full <= walmost_full_val;
      wlevel       <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       winc = 1'b0;
  logic [4:0] rptr = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;
  logic       wovf_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  wptr_full_ctrl #(
    .ADDRSIZE    (4),
    .AFULL_LEVEL (14)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow),
    .wovf_clr     (wovf_clr)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1ns after the
  // rising edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge wclk);
    wrst = 1'b1;
    winc = 1'b1;
    #1;
    vectors++;
    if (wen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wen_during: got %b expected 0", wen);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got wen=%b waddr=%0d wptr=%b wfull=%b af=%b wlevel=%0d ovf=%b expected all 0",
                 wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow);
      end
    end
    @(negedge wclk);
    wrst = 1'b0;
    #1;
    vectors++;
    if (wen !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wen_release: got %b expected 1", wen);
    end
    winc = 1'b0;
  endtask

  task automatic test_fill();
    @(negedge wclk);
    rptr = '0;
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      vectors++;
      if (wlevel !== 5'(i) || waddr !== 4'(i) || wptr !== gray(5'(i))) begin
        miscompares++;
        $display("FAIL fill_ptr[%0d]: got wlevel=%0d waddr=%0d wptr=%b expected %0d %0d %b",
                 i, wlevel, waddr, wptr, i, i % 16, gray(5'(i)));
      end
      vectors++;
      if (walmost_full !== (i >= 14)) begin
        miscompares++;
        $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full, i >= 14);
      end
      vectors++;
      if (wfull !== (i == 16)) begin
        miscompares++;
        $display("FAIL fill_full[%0d]: got %b expected %b", i, wfull, i == 16);
      end
    end
    vectors++;
    if (wptr !== 5'b11000 || waddr !== 4'd0 || wlevel !== 5'd16) begin
      miscompares++;
      $display("FAIL fill_final: got wptr=%b waddr=%0d wlevel=%0d expected 11000 0 16",
               wptr, waddr, wlevel);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      #1;
      vectors++;
      if (wen !== 1'b0) begin
        miscompares++;
        $display("FAIL ovf_wen[%0d]: got %b expected 0", i, wen);
      end
      step();
      vectors++;
      if (wptr !== 5'b11000 || waddr !== 4'd0 || wfull !== 1'b1 || woverflow !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_hold[%0d]: got wptr=%b waddr=%0d wfull=%b ovf=%b expected 11000 0 1 1",
                 i, wptr, waddr, wfull, woverflow);
      end
    end
    @(negedge wclk);
    winc = 1'b0;
    wovf_clr = 1'b1;
    step();
    vectors++;
    if (woverflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b expected 0", woverflow);
    end
    @(negedge wclk);
    winc = 1'b1;
    wovf_clr = 1'b1;
    step();
    vectors++;
    if (woverflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got %b expected 1", woverflow);
    end
    @(negedge wclk);
    winc = 1'b0;
    wovf_clr = 1'b0;
  endtask

  task automatic test_drain();
    @(negedge wclk);
    rptr = 5'b00110;
    for (int e = 1; e <= 3; e++) begin
      step();
      vectors++;
      if (e < 3 && (wfull !== 1'b1 || wlevel !== 5'd16 || walmost_full !== 1'b1)) begin
        miscompares++;
        $display("FAIL drain_lag[%0d]: got wfull=%b wlevel=%0d af=%b expected 1 16 1",
                 e, wfull, wlevel, walmost_full);
      end
      if (e == 3 && (wfull !== 1'b0 || wlevel !== 5'd12 || walmost_full !== 1'b0)) begin
        miscompares++;
        $display("FAIL drain_edge3: got wfull=%b wlevel=%0d af=%b expected 0 12 0",
                 wfull, wlevel, walmost_full);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] wb;
    logic [4:0] prev;
    wb = 5'd16;
    @(negedge wclk);
    rptr = gray(wb);
    repeat (3) step();
    vectors++;
    if (wlevel !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_start_level: got %0d expected 0", wlevel);
    end
    prev = wptr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge wclk);
      rptr = gray(wb);
      winc = 1'b1;
      step();
      wb = wb + 5'd1;
      vectors++;
      if ($countones(wptr ^ prev) != 1 || wptr !== gray(wb)) begin
        miscompares++;
        $display("FAIL wrap_gray[%0d]: got wptr=%b prev=%b expected %b", k, wptr, prev, gray(wb));
      end
      vectors++;
      if (waddr !== wb[3:0] || wptr[4] !== wb[4]) begin
        miscompares++;
        $display("FAIL wrap_addr[%0d]: got waddr=%0d msb=%b expected %0d %b",
                 k, waddr, wptr[4], wb[3:0], wb[4]);
      end
      vectors++;
      if (wfull !== 1'b0 || wlevel > 5'd8) begin
        miscompares++;
        $display("FAIL wrap_level[%0d]: got wfull=%b wlevel=%0d expected 0 <=8", k, wfull, wlevel);
      end
      prev = wptr;
    end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  task automatic test_reset_mid();
    // write pointer sits at binary 24 after the wrap test
    @(negedge wclk);
    rptr = gray(5'd14);
    repeat (3) step();
    vectors++;
    if (wlevel !== 5'd10) begin
      miscompares++;
      $display("FAIL mid_level: got %0d expected 10", wlevel);
    end
    @(negedge wclk);
    wrst = 1'b1;
    rptr = '0;
    step();
    vectors++;
    if ({waddr, wptr, wfull, walmost_full, wlevel, woverflow} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got waddr=%0d wptr=%b wfull=%b af=%b wlevel=%0d ovf=%b expected all 0",
               waddr, wptr, wfull, walmost_full, wlevel, woverflow);
    end
    @(negedge wclk);
    wrst = 1'b0;
    winc = 1'b1;
    step();
    vectors++;
    if (waddr !== 4'd1 || wptr !== 5'b00001 || wlevel !== 5'd1) begin
      miscompares++;
      $display("FAIL mid_first_write: got waddr=%0d wptr=%b wlevel=%0d expected 1 00001 1",
               waddr, wptr, wlevel);
    end
    @(negedge wclk);
    winc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and status controller for the asynchronous FIFO, working alongside the read-side pointer/empty logic. It runs in the write clock domain and synchronises the read domain's Gray read pointer through an internal two-flop synchroniser. It generates the binary RAM write address, the Gray write pointer exported to the read domain, and the registered full status. It also provides almost-full, a fill-level estimate, and a sticky overflow flag.

## Interface
- ADDRSIZE, 4: RAM address width; depth = 2^ADDRSIZE; legal values ≥ 2.
- AFULL_LEVEL, 14: walmost_full asserts when the fill level is ≥ this value; legal range 1..2^ADDRSIZE.

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  reset, synchronous to wclk, active-high.
- winc  in  1  write request from the producer.
- rptr  in  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to wclk.
- wen  out  1  RAM write enable, combinational: winc & ~wfull.
- waddr  out  ADDRSIZE  RAM write address: low bits of the binary write counter.
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered fill level, range 0..2^ADDRSIZE.
- woverflow  out  1  sticky flag: a write was attempted while the FIFO was full.
- wovf_clr  in  1  clears woverflow.

## Operation
- Read-pointer synchroniser: rptr → wq1_rptr → wq2_rptr, both stages clocked by wclk and reset to 0.
- wbinnext = wbin + (winc & ~wfull), computed modulo 2^(ADDRSIZE+1).
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- Each wclk edge registers wbin ← wbinnext and wptr ← wgraynext. waddr = wbin[ADDRSIZE-1:0].
- Full condition, registered into wfull: wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr.
  - level_next = wbinnext − rbin_s, modulo 2^(ADDRSIZE+1); registered into wlevel.
  - walmost_full ← (level_next ≥ AFULL_LEVEL).
- Write while full (winc & wfull): the write is dropped; wbin, wptr and waddr hold; wen = 0.
- Overflow: woverflow ← 1 if winc & wfull, else 0 if wovf_clr, else it holds. Set wins over a simultaneous clear.
- wlevel is a conservative estimate: it may over-report by up to the synchroniser lag. It never under-reports.
- Reset (wrst high at a wclk edge) clears wbin, wptr, waddr, wq1/wq2, wfull, walmost_full, wlevel and woverflow to 0, including mid-operation. The read domain must be reset in the same window; the block performs no cross-domain reset handling.

## Timing
- A write accepted at edge k updates wptr, waddr, wlevel and walmost_full at edge k.
- wfull rises at the edge that accepts the write making the FIFO full. The next winc is therefore blocked with zero lag.
- Read progress reaches wfull/wlevel at the third wclk edge after rptr changes: two synchroniser stages plus the status register.
- wptr changes at most one bit per wclk; it is glitch-free for the read-side synchroniser.
- wen is combinational from winc and registered wfull. There is no combinational path from rptr to any output.

## Structure
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width via a typed argument of ADDRSIZE+1 bits.
  - The default ADDRSIZE constant, shared with the read side.
- Sub-module sync_r2w: a parameterised-width two-flop synchroniser with synchronous active-high reset, instantiated once for rptr.
- Everything else lives in wptr_full_ctrl.

## Test plan
All scenarios use ADDRSIZE = 4 and AFULL_LEVEL = 14.
- **Reset:** wrst high for 2 cycles with winc=1 → all outputs 0; wen=1 only after release.
- **Fill:** rptr=0, winc=1 for 16 cycles →
  - walmost_full=1 at the 14th write edge.
  - wfull=1 at the 16th write edge, with wptr=5'b11000, waddr=0, wlevel=16.
- **Overflow:** keep winc=1 for 3 more cycles →
  - wptr holds, wen=0, woverflow=1.
  - wovf_clr alone → woverflow=0 next edge.
  - wovf_clr together with winc&wfull → woverflow stays 1.
- **Drain:** from full, drive rptr=5'b00110 (Gray of 4) → wfull=0 and wlevel=12 at the 3rd edge; walmost_full=0 at the same edge.
- **Wrap-around:** 40 writes with rptr advanced to keep level ≤ 8 →
  - wptr changes by exactly one bit per accepted write.
  - waddr wraps 15→0; wbin MSB toggles at writes 16 and 32; wfull never asserts.
- **Reset mid-operation:** at wlevel=10, pulse wrst for 1 cycle → all outputs 0 at that edge; the next write yields waddr=1 and wptr=5'b00001.
